// File: rtl/spu_program_loader_if.sv
// Command/data stream from the boot host into the SPU program loader.
// The source (master) drives word and valid; the loader (slave) answers with ready.
interface spu_program_loader_if;
    logic [0:31] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/spu_program_loader.sv
// Boot loader ahead of the SPU core: decodes header/payload words into registered
// instruction, register-file and local-store preload strobes, then releases the core on RUN.
module spu_program_loader #(
    parameter int IMEM_AW = 10,
    parameter int RF_AW   = 7,
    parameter int LS_AW   = 15,
    parameter int QW      = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    spu_program_loader_if.slave  stream,
    output logic                 load_en,
    output logic [0:IMEM_AW-1]   instr_load_addr,
    output logic [0:31]          instruction_in,
    output logic                 preload_en,
    output logic [0:RF_AW-1]     preload_addr,
    output logic [0:QW-1]        preload_values,
    output logic                 preload_LS_en,
    output logic [0:LS_AW-1]     preload_LS_addr,
    output logic [0:QW-1]        preload_LS_data,
    output logic                 core_run,
    output logic                 busy
);

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_INSTR = 3'd1;
    localparam logic [2:0] ST_REG   = 3'd2;
    localparam logic [2:0] ST_LS    = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    logic [2:0]      state_r;
    logic [2:0]      state_next_s;
    logic [2:0]      hdr_next_s;
    logic [14:0]     base_r;
    logic [14:0]     count_r;
    logic [14:0]     idx_r;
    logic [1:0]      word_k_r;
    logic [QW-33:0]  partial_r;
    logic [QW-1:0]   qw_next_s;
    logic            xfer_s;
    logic            last_item_s;
    logic [14:0]     hdr_base_s;
    logic [14:0]     hdr_count_s;
    logic [1:0]      hdr_cmd_s;

    assign xfer_s      = stream.in_valid & stream.in_ready;
    assign hdr_cmd_s   = stream.in_data[0:1];
    assign hdr_base_s  = stream.in_data[2:16];
    assign hdr_count_s = stream.in_data[17:31];
    assign last_item_s = (idx_r == (count_r - 15'd1));
    // First accepted word of a quadword ends up in the most significant slot.
    assign qw_next_s   = {partial_r, stream.in_data};

    // Header decode: a zero-count load is a no-op, RUN ignores the count field.
    always_comb begin
        hdr_next_s = ST_HDR;
        case (hdr_cmd_s)
            2'b00:   hdr_next_s = (hdr_count_s == 15'd0) ? ST_HDR : ST_INSTR;
            2'b01:   hdr_next_s = (hdr_count_s == 15'd0) ? ST_HDR : ST_REG;
            2'b10:   hdr_next_s = (hdr_count_s == 15'd0) ? ST_HDR : ST_LS;
            2'b11:   hdr_next_s = ST_RUN;
            default: hdr_next_s = ST_HDR;
        endcase
    end

    // Next-state selection; an item completes on its last accepted word.
    always_comb begin
        state_next_s = state_r;
        if (xfer_s) begin
            case (state_r)
                ST_HDR:   state_next_s = hdr_next_s;
                ST_INSTR: state_next_s = last_item_s ? ST_HDR : ST_INSTR;
                ST_REG:   state_next_s = ((word_k_r == 2'd3) && last_item_s) ? ST_HDR : ST_REG;
                ST_LS:    state_next_s = ((word_k_r == 2'd3) && last_item_s) ? ST_HDR : ST_LS;
                ST_RUN:   state_next_s = ST_RUN;
                default:  state_next_s = ST_HDR;
            endcase
        end else begin
            state_next_s = (state_r > ST_RUN) ? ST_HDR : state_r;
        end
    end

    // State, payload sequencing and all registered core-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_HDR;
            base_r          <= 15'd0;
            count_r         <= 15'd0;
            idx_r           <= 15'd0;
            word_k_r        <= 2'd0;
            partial_r       <= {(QW-32){1'b0}};
            stream.in_ready <= 1'b0;
            load_en         <= 1'b0;
            instr_load_addr <= {IMEM_AW{1'b0}};
            instruction_in  <= 32'd0;
            preload_en      <= 1'b0;
            preload_addr    <= {RF_AW{1'b0}};
            preload_values  <= {QW{1'b0}};
            preload_LS_en   <= 1'b0;
            preload_LS_addr <= {LS_AW{1'b0}};
            preload_LS_data <= {QW{1'b0}};
            core_run        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            stream.in_ready <= (state_next_s != ST_RUN);
            core_run        <= (state_next_s == ST_RUN);
            busy            <= (state_next_s == ST_INSTR) || (state_next_s == ST_REG) ||
                               (state_next_s == ST_LS);
            load_en         <= 1'b0;
            preload_en      <= 1'b0;
            preload_LS_en   <= 1'b0;
            if (xfer_s) begin
                case (state_r)
                    ST_HDR: begin
                        base_r   <= hdr_base_s;
                        count_r  <= hdr_count_s;
                        idx_r    <= 15'd0;
                        word_k_r <= 2'd0;
                    end
                    ST_INSTR: begin
                        load_en         <= 1'b1;
                        instr_load_addr <= base_r[IMEM_AW-1:0] + idx_r[IMEM_AW-1:0];
                        instruction_in  <= stream.in_data;
                        idx_r           <= idx_r + 15'd1;
                    end
                    ST_REG, ST_LS: begin
                        partial_r <= qw_next_s[QW-33:0];
                        word_k_r  <= word_k_r + 2'd1;
                        if (word_k_r == 2'd3) begin
                            idx_r <= idx_r + 15'd1;
                            if (state_r == ST_REG) begin
                                preload_en     <= 1'b1;
                                preload_addr   <= base_r[RF_AW-1:0] + idx_r[RF_AW-1:0];
                                preload_values <= qw_next_s;
                            end else begin
                                preload_LS_en   <= 1'b1;
                                preload_LS_addr <= base_r[LS_AW-1:0] + idx_r[LS_AW-1:0];
                                preload_LS_data <= qw_next_s;
                            end
                        end else begin
                            idx_r <= idx_r;
                        end
                    end
                    default: begin
                        idx_r <= idx_r;
                    end
                endcase
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_spu_program_loader.sv
// Bench for spu_program_loader: directed boot scenarios plus randomized command streams,
// checked against an item-level model of the expected preload writes.
module tb_spu_program_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_en, preload_en, preload_LS_en, core_run, busy;
    logic [0:9]   instr_load_addr;
    logic [0:31]  instruction_in;
    logic [0:6]   preload_addr;
    logic [0:127] preload_values;
    logic [0:14]  preload_LS_addr;
    logic [0:127] preload_LS_data;

    spu_program_loader_if stream_if ();

    spu_program_loader dut (
        .clk             (clk),
        .rst             (rst),
        .stream          (stream_if),
        .load_en         (load_en),
        .instr_load_addr (instr_load_addr),
        .instruction_in  (instruction_in),
        .preload_en      (preload_en),
        .preload_addr    (preload_addr),
        .preload_values  (preload_values),
        .preload_LS_en   (preload_LS_en),
        .preload_LS_addr (preload_LS_addr),
        .preload_LS_data (preload_LS_data),
        .core_run        (core_run),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [14:0]  addr;
        logic [127:0] data;
        int           cyc;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    wr_t         mon_w;
    logic [31:0] pay_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nstb;

    always @(posedge clk) cyc++;

    // Capture every write strobe seen by the core; two at once is a fault.
    always @(negedge clk) begin
        if (rst) begin
            nstb = int'(load_en) + int'(preload_en) + int'(preload_LS_en);
            if (nstb != 0) begin
                checks++;
                if (nstb > 1) begin
                    errors++;
                    $display("FAIL strobe_overlap: %0d strobes high, at most 1 allowed", nstb);
                end
                mon_w.cyc = cyc;
                if (load_en) begin
                    mon_w.kind = 0; mon_w.addr = {5'd0, instr_load_addr};
                    mon_w.data = {96'd0, instruction_in};
                end else if (preload_en) begin
                    mon_w.kind = 1; mon_w.addr = {8'd0, preload_addr}; mon_w.data = preload_values;
                end else begin
                    mon_w.kind = 2; mon_w.addr = preload_LS_addr; mon_w.data = preload_LS_data;
                end
                obs_q.push_back(mon_w);
            end
        end
    end

    task automatic push_exp(input int kind, input int addr, input logic [127:0] data);
        wr_t w;
        w.kind = kind; w.addr = addr[14:0]; w.data = data; w.cyc = 0;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            stream_if.in_valid = 1'b0;
            stream_if.in_data  = $urandom;
        end
        @(negedge clk);
        stream_if.in_valid = 1'b1;
        stream_if.in_data  = w;
        while (!stream_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
            stream_if.in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            stream_if.in_valid = 1'b0;
        end
    endtask

    task automatic check_writes(input string name);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr ||
                    obs_q[i].data !== exp_q[i].data) begin
                    errors++;
                    $display("FAIL %s_write%0d: got kind %0d addr %0d data %h, expected kind %0d addr %0d data %h",
                             name, i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data,
                             exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Expected writes for one command, from the header rules over the payload in pay_q.
    task automatic model_cmd(input int cmd, input int base, input int count);
        for (int i = 0; i < count; i++) begin
            if (cmd == 0)
                push_exp(0, ((base % 1024) + i) % 1024, {96'd0, pay_q[i]});
            else if (cmd == 1)
                push_exp(1, ((base % 128) + i) % 128,
                         {pay_q[4*i], pay_q[4*i+1], pay_q[4*i+2], pay_q[4*i+3]});
            else
                push_exp(2, (base + i) % 32768,
                         {pay_q[4*i], pay_q[4*i+1], pay_q[4*i+2], pay_q[4*i+3]});
        end
    endtask

    task automatic run_cmd(input int cmd, input int base, input int count, input int maxgap);
        logic [1:0]  c2;
        logic [14:0] b15, n15;
        int          nw;
        c2 = cmd[1:0]; b15 = base[14:0]; n15 = count[14:0];
        nw = (cmd == 0) ? count : 4 * count;
        pay_q.delete();
        for (int i = 0; i < nw; i++) pay_q.push_back($urandom);
        send({c2, b15, n15}, $urandom_range(0, maxgap));
        @(negedge clk);
        stream_if.in_valid = 1'b0;
        checks++;
        if (busy !== (count != 0)) begin
            errors++;
            $display("FAIL rand_busy: busy=%b, expected %b (count %0d)", busy, count != 0, count);
        end
        for (int i = 0; i < nw; i++) send(pay_q[i], $urandom_range(0, maxgap));
        model_cmd(cmd, base, count);
        idle(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_busy_end: busy=%b, expected 0", busy);
        end
        check_writes("rand");
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stream_if.in_valid = 1'b0;
        stream_if.in_data  = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({load_en, preload_en, preload_LS_en, core_run, busy, stream_if.in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: strobes/run/busy/ready=%b, expected 000000",
                     {load_en, preload_en, preload_LS_en, core_run, busy, stream_if.in_ready});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stream_if.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, expected 1 0", stream_if.in_ready, busy);
        end
    endtask

    task automatic test_instr();
        send(32'h0002_8002, 0);
        send(32'hAAAA_0001, 0);
        send(32'hBBBB_0002, 0);
        @(negedge clk);
        stream_if.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL instr_busy: busy=%b after last word, expected 0", busy);
        end
        idle(3);
        checks++;
        if (obs_q.size() == 2 && (obs_q[1].cyc - obs_q[0].cyc) != 1) begin
            errors++;
            $display("FAIL instr_b2b: strobes %0d cycles apart, expected 1", obs_q[1].cyc - obs_q[0].cyc);
        end
        push_exp(0, 5, 128'hAAAA_0001);
        push_exp(0, 6, 128'hBBBB_0002);
        check_writes("instr");
    endtask

    task automatic test_wrap();
        logic [31:0] w0, w1;
        w0 = $urandom; w1 = $urandom;
        send(32'h01FF_8002, 0);
        send(w0, 0);
        send(w1, 0);
        idle(4);
        push_exp(0, 1023, {96'd0, w0});
        push_exp(0, 0, {96'd0, w1});
        check_writes("wrap");
    endtask

    task automatic test_reg();
        send(32'h4001_8001, 0);
        send(32'h1111_1111, 0);
        send(32'h2222_2222, 0);
        send(32'h3333_3333, 0);
        send(32'h4444_4444, 0);
        idle(4);
        push_exp(1, 3, 128'h11111111_22222222_33333333_44444444);
        check_writes("reg");
    endtask

    task automatic test_ls_gap();
        logic [31:0] w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        send(32'h8000_0001, 0);
        send(w[0], 0);
        send(w[1], 0);
        idle(3);
        send(w[2], 0);
        idle(1);
        #2;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL ls_gap_early: %0d writes before 4th word, expected 0", obs_q.size());
        end
        send(w[3], 0);
        idle(4);
        push_exp(2, 0, {w[0], w[1], w[2], w[3]});
        check_writes("ls_gap");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int base;
            base = (it % 3 == 0) ? 32767 - $urandom_range(0, 2) : $urandom_range(0, 32767);
            run_cmd($urandom_range(0, 2), base, $urandom_range(0, 4), 2);
        end
    endtask

    task automatic test_reset_mid();
        send(32'h8000_0001, 0);
        send(32'hDEAD_0001, 0);
        send(32'hDEAD_0002, 0);
        #2;
        rst = 1'b0;
        stream_if.in_valid = 1'b0;
        #1;
        checks++;
        if ({load_en, preload_en, preload_LS_en, core_run, busy} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: strobes/run/busy=%b, expected 00000",
                     {load_en, preload_en, preload_LS_en, core_run, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        send(32'h8003_8001, 0);
        send(32'h0000_00A1, 0);
        send(32'h0000_00A2, 0);
        send(32'h0000_00A3, 0);
        send(32'h0000_00A4, 0);
        idle(4);
        push_exp(2, 7, {32'hA1, 32'hA2, 32'hA3, 32'hA4});
        check_writes("midreset");
    endtask

    task automatic test_run();
        send(32'hC000_0000, 0);
        @(negedge clk);
        #1;
        checks++;
        if (core_run !== 1'b1 || stream_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_enter: core_run=%b in_ready=%b, expected 1 0", core_run, stream_if.in_ready);
        end
        stream_if.in_valid = 1'b1;
        stream_if.in_data  = 32'h0000_0001;
        repeat (4) @(negedge clk);
        stream_if.in_data  = 32'h1234_5678;
        repeat (4) @(negedge clk);
        stream_if.in_valid = 1'b0;
        #2;
        checks++;
        if (core_run !== 1'b1 || stream_if.in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_hold: core_run=%b in_ready=%b busy=%b, expected 1 0 0",
                     core_run, stream_if.in_ready, busy);
        end
        check_writes("run");
    endtask

    initial begin
        test_reset();
        test_instr();
        test_wrap();
        test_reg();
        test_ls_gap();
        test_random();
        test_reset_mid();
        test_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
